// File: rtl/bf8b_pkg.sv
// Shared types and default widths for the memory port arbiter.
package bf8b_pkg;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        DONE  = 2'b11
    } arb_state_t;

    // Identity of the requester owning the memory port
    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } req_id_t;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the fetch stage (reads) and the execute
// stage (reads/writes). One transaction at a time: grant in IDLE, drive the
// port in ISSUE, wait out the read latency, then pulse the winner's ack.
module mem_port_arbiter
    import bf8b_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int RD_LAT    = 1,
    parameter int EXEC_PRIO = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              e_req,
    input  logic              e_we,
    input  logic [ADDR_W-1:0] e_addr,
    input  logic [DATA_W-1:0] e_wdata,
    output logic              e_ack,
    output logic [DATA_W-1:0] e_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int              CNT_W     = $clog2(RD_LAT + 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

    arb_state_t        state_r;
    arb_state_t        state_s;
    req_id_t           grant_id_s;
    logic              grant_s;
    req_id_t           win_r;
    req_id_t           last_grant_r;
    logic              we_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              mem_we_r;
    logic              f_ack_r;
    logic              e_ack_r;
    logic [DATA_W-1:0] f_rdata_r;
    logic [DATA_W-1:0] e_rdata_r;

    // Next-state logic and arbitration (grant decided only in IDLE)
    always_comb begin
        state_s    = state_r;
        grant_s    = 1'b0;
        grant_id_s = FETCH;
        case (state_r)
            IDLE: begin
                if (f_req && e_req) begin
                    grant_s = 1'b1;
                    state_s = ISSUE;
                    if (EXEC_PRIO != 0) begin
                        grant_id_s = EXEC;
                    end else if (last_grant_r == FETCH) begin
                        grant_id_s = EXEC;
                    end else begin
                        grant_id_s = FETCH;
                    end
                end else if (e_req) begin
                    grant_s    = 1'b1;
                    grant_id_s = EXEC;
                    state_s    = ISSUE;
                end else if (f_req) begin
                    grant_s    = 1'b1;
                    grant_id_s = FETCH;
                    state_s    = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (RD_LAT == 1) begin
                    state_s = DONE;
                end else begin
                    state_s = WAIT;
                end
            end
            WAIT: begin
                if (cnt_r <= CNT_ONE) begin
                    state_s = DONE;
                end else begin
                    state_s = WAIT;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register and read-latency down-counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            if (state_r == ISSUE) begin
                cnt_r <= WAIT_LOAD;
            end else if ((state_r == WAIT) && (cnt_r != CNT_ZERO)) begin
                cnt_r <= cnt_r - CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Grant latching, memory port drive, ack pulses and read-data capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_r        <= FETCH;
            last_grant_r <= FETCH;
            we_r         <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= '0;
            mem_we_r     <= 1'b0;
            f_ack_r      <= 1'b0;
            e_ack_r      <= 1'b0;
            f_rdata_r    <= '0;
            e_rdata_r    <= '0;
        end else begin
            // The port registers load at the grant edge, so their values
            // appear during ISSUE and mem_addr holds until the next grant.
            if (grant_s) begin
                win_r        <= grant_id_s;
                last_grant_r <= grant_id_s;
                if (grant_id_s == EXEC) begin
                    we_r        <= e_we;
                    mem_we_r    <= e_we;
                    mem_addr_r  <= e_addr;
                    mem_wdata_r <= e_wdata;
                end else begin
                    we_r        <= 1'b0;
                    mem_we_r    <= 1'b0;
                    mem_addr_r  <= f_addr;
                    mem_wdata_r <= '0;
                end
            end else begin
                mem_we_r <= 1'b0;
            end

            f_ack_r <= (state_s == DONE) && (win_r == FETCH);
            e_ack_r <= (state_s == DONE) && (win_r == EXEC);

            if ((state_r == DONE) && (win_r == FETCH)) begin
                f_rdata_r <= mem_rdata;
            end else begin
                f_rdata_r <= f_rdata_r;
            end

            if ((state_r == DONE) && (win_r == EXEC) && !we_r) begin
                e_rdata_r <= mem_rdata;
            end else begin
                e_rdata_r <= e_rdata_r;
            end
        end
    end

    // Memory data only becomes valid in the DONE cycle, so read data is
    // forwarded straight through while the ack is high and held afterwards.
    assign f_rdata   = f_ack_r ? mem_rdata : f_rdata_r;
    assign e_rdata   = (e_ack_r && !we_r) ? mem_rdata : e_rdata_r;
    assign f_ack     = f_ack_r;
    assign e_ack     = e_ack_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_we    = mem_we_r;

endmodule
